// File: rtl/kband_mem_pkg.sv
// Shared types and constants for the KBand memory stream reader.
package kband_mem_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 14;
  localparam int BE_W   = DATA_W / 8;

  // Reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One captured memory word plus the end-of-block marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/kband_sync_fifo.sv
// Small synchronous FIFO with a registered show-ahead head word.
// The head register always holds the oldest entry, so the consumer sees
// data straight from a flop rather than through the storage read mux.
module kband_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok;
  logic             pop_ok;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign count     = count_reg;
  assign head_data = head_reg;

  // Storage write; no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the show-ahead head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The incoming word becomes the head when nothing older survives this edge.
      if (push_ok && (empty || (count_reg == CNT_W'(1) && pop_ok))) begin
        head_reg <= push_data;
      end else if (pop_ok && count_reg > CNT_W'(1)) begin
        head_reg <= mem_reg[ptr_inc(rd_ptr_reg)];
      end
    end
  end

endmodule

// File: rtl/kband_mem_stream_reader.sv
// Avalon-MM read master that streams a contiguous block of on-chip memory
// words out on a ready/valid source. Reads are issued one per cycle while
// FIFO credit remains; back-pressure simply withholds further reads.
module kband_mem_stream_reader #(
  parameter int DATA_W     = kband_mem_pkg::DATA_W,
  parameter int ADDR_W     = kband_mem_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_last
);
  import kband_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  state_e            state_reg;
  logic [ADDR_W:0]   reads_left_reg;
  logic [ADDR_W-1:0] next_addr_reg;
  logic              cs_last_reg;
  logic              outstanding_reg;
  logic              cap_last_reg;

  fifo_entry_t       push_entry;
  fifo_entry_t       head_entry;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic              credit_ok;
  logic              issue;

  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  assign pop      = st_valid & st_ready;
  assign st_valid = ~fifo_empty;
  assign st_data  = head_entry.data;
  assign st_last  = head_entry.last & ~fifo_empty;

  // Words already held, being captured, or being read this cycle must
  // leave room for one more, even if the sink stalls from now on.
  assign credit_ok = (32'(fifo_count) + 32'(outstanding_reg) + 32'(mem_chipselect))
                     < 32'(FIFO_DEPTH);
  assign issue     = (reads_left_reg != '0) && credit_ok;

  assign push_entry.last = cap_last_reg;
  assign push_entry.data = mem_readdata;

  kband_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (outstanding_reg),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Control FSM, address/remaining counters and the one-deep capture pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      reads_left_reg  <= '0;
      next_addr_reg   <= '0;
      mem_address     <= '0;
      mem_chipselect  <= 1'b0;
      cs_last_reg     <= 1'b0;
      outstanding_reg <= 1'b0;
      cap_last_reg    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      outstanding_reg <= mem_chipselect;
      cap_last_reg    <= cs_last_reg & mem_chipselect;
      mem_chipselect  <= 1'b0;
      cs_last_reg     <= 1'b0;
      done            <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              mem_chipselect <= 1'b1;
              mem_address    <= base_addr;
              next_addr_reg  <= base_addr + 1'b1;
              reads_left_reg <= word_count - CNT_ONE;
              cs_last_reg    <= (word_count == CNT_ONE);
              busy           <= 1'b1;
              state_reg      <= (word_count == CNT_ONE) ? DRAIN : READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_chipselect <= 1'b1;
            mem_address    <= next_addr_reg;
            next_addr_reg  <= next_addr_reg + 1'b1;
            reads_left_reg <= reads_left_reg - CNT_ONE;
            cs_last_reg    <= (reads_left_reg == CNT_ONE);
            if (reads_left_reg == CNT_ONE) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && head_entry.last) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A capture into a full FIFO means the credit arithmetic is broken.
  assert property (@(posedge clk) disable iff (reset) !(outstanding_reg && fifo_full));

endmodule

// File: doc/kband_mem_stream_reader.md
# kband_mem_stream_reader

Avalon-MM read master that pulls a contiguous block of 128-bit words from the 16384 x 128 single-port on-chip FPGA-slave memory and streams it out on a ready/valid source toward the KBand alignment core. It is the initiating end of the on-chip memory's slave port. It issues one read per cycle while credit remains, captures the fixed one-cycle-latency read data into a small FIFO, and applies back-pressure from the stream side by withholding reads.

## Interface
Parameters:
- DATA_W, 128, memory and stream word width
- ADDR_W, 14, word address width (memory depth 2^ADDR_W)
- FIFO_DEPTH, 4, capture FIFO entries; must be >= 4 for full throughput

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- word_count  in  ADDR_W+1  words to read, 0..16384, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- mem_address  out  ADDR_W  read address
- mem_chipselect  out  1  read strobe; one read per high cycle
- mem_write  out  1  tied 0
- mem_byteenable  out  DATA_W/8  tied all ones
- mem_clken  out  1  tied 1
- mem_readdata  in  DATA_W  valid exactly one cycle after mem_chipselect
- st_data  out  DATA_W  FIFO head
- st_valid  out  1  FIFO non-empty
- st_ready  in  1  sink accepts when st_valid & st_ready
- st_last  out  1  marks the final word of the block

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on start when word_count != 0.
  - IDLE stays IDLE on start with word_count == 0; done pulses on the next cycle and busy stays low.
  - READ -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on the handshake of the word with st_last.
- A read is issued (mem_chipselect=1) in READ when reads_left != 0 and outstanding + occupancy < FIFO_DEPTH.
  - outstanding: reads issued whose data has not yet been captured (0 or 1).
- Address counter:
  - Starts at base_addr; increments by 1 per issued read.
  - Wraps modulo 2^ADDR_W: base 16383 -> 16383, 0, 1, ...
- Capture: one cycle after an issued read, mem_readdata is pushed into the FIFO together with a last flag. The last flag is set for the read issued when reads_left == 1.
- The FIFO can never overflow; the credit rule guarantees this. Overflow is a bug and is asserted in simulation.
- start while busy is ignored, with no effect on the counters.
- reset at any time:
  - FSM returns to IDLE; FIFO, counters and outstanding are cleared.
  - Any in-flight read data is discarded and no done pulse is produced.
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_last=0, st_data=0.

## Timing
- Cycle 0: start accepted.
- Cycle 1: busy=1, first read issued at base_addr.
- Cycle 2: data captured into the FIFO.
- Cycle 3: st_valid=1 with word 0.
- Steady state, st_ready held high: 1 word per cycle; N words complete their handshakes in cycles 3..N+2.
- done pulses and busy falls on the cycle after the st_last handshake.
- st_ready low: reads stop once outstanding + occupancy reaches FIFO_DEPTH. st_data and st_valid hold stable while st_valid & ~st_ready.
- mem_address and mem_chipselect are registered outputs; no combinational path from st_ready to memory ports.

## Structure
- Package kband_mem_pkg:
  - DATA_W, ADDR_W, BE_W=DATA_W/8
  - FSM state enum (IDLE, READ, DRAIN)
  - FIFO entry type {last, data}
- Sub-module kband_sync_fifo:
  - Parameterised width/depth.
  - Push/pop, occupancy count, empty/full.
  - Registered head, show-ahead output.
- The top level holds the FSM, address and remaining counters, outstanding flag, and credit logic.

## Test plan
- base 0x0010, count 8, st_ready=1 -> addresses 0x0010..0x0017 issued in cycles 1..8; data words 0..7 in order; st_last on word 7; done in cycle 11.
- base 0x3FFE, count 4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; data correct across the wrap.
- count 16, st_ready low for cycles 4..20 -> at most 4 reads issued before the stall; no FIFO overflow; st_data stable during stall; all 16 words delivered in order.
- count 0 -> no mem_chipselect, busy never high, done pulse on cycle 1.
- reset asserted during READ after 5 of 32 reads -> all outputs at reset values the next cycle; no done. A subsequent start with count 3 delivers exactly 3 fresh words.
- start pulsed while busy (count 10 run, second start with count 2) -> ignored; exactly 10 words and one done.
